// File: rtl/rv_defs.sv
// Shared RV32I fetch definitions: opcodes, the bubble word and the fetch FSM encoding.
package rv_defs;

  localparam logic [6:0]  OP_B_TYPE = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/static_predictor.sv
// Static predictor: backward B-type branches and JAL are taken, everything else falls through.
module static_predictor
  import rv_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  logic [31:0] imm_b;
  logic [31:0] imm_j;

  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc + 32'd4;
    if (instr[6:0] == OP_B_TYPE && instr[31]) begin
      pred_taken  = 1'b1;
      pred_target = pc + imm_b;
    end else if (instr[6:0] == OP_JAL) begin
      pred_taken  = 1'b1;
      pred_target = pc + imm_j;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, boot/run/halt FSM, static prediction,
// decode redirect/stall handling and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        npc_control,
  input  logic [31:0] jump_target_PC,
  input  logic        wait_signal,
  input  logic        halt,
  output logic [31:0] PC_Dec,
  output logic [31:0] instruction_Dec,
  output logic        valid_Dec,
  output logic        pred_taken_Dec,
  output logic [15:0] redirect_count
);

  import rv_defs::*;

  state_e      state, state_next;
  logic [31:0] pc, pc_next;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        load_bubble;
  logic        load_fetch;

  assign imem_addr = {pc[31:2], 2'b00};

  static_predictor u_predictor (
    .pc          (pc),
    .instr       (imem_data),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    load_bubble = 1'b0;
    load_fetch  = 1'b0;

    unique case (state)
      ST_BOOT: begin
        state_next  = ST_RUN;
        load_bubble = 1'b1;
      end
      ST_RUN: begin
        if (halt) state_next = ST_HALT;
      end
      ST_HALT: begin
        load_bubble = 1'b1;
        if (!halt) state_next = ST_RUN;
      end
      default: state_next = ST_BOOT;
    endcase

    // A redirect beats a stall and is honoured in every state; only RUN fetches.
    if (npc_control) begin
      pc_next     = jump_target_PC & ~32'h1;
      load_bubble = 1'b1;
    end else if (state == ST_RUN && !wait_signal) begin
      pc_next    = pred_target;
      load_fetch = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      PC_Dec          <= 32'h0;
      instruction_Dec <= NOP_INSTR;
      valid_Dec       <= 1'b0;
      pred_taken_Dec  <= 1'b0;
    end else if (load_bubble) begin
      instruction_Dec <= NOP_INSTR;
      valid_Dec       <= 1'b0;
      pred_taken_Dec  <= 1'b0;
    end else if (load_fetch) begin
      PC_Dec          <= pc;
      instruction_Dec <= imem_data;
      valid_Dec       <= 1'b1;
      pred_taken_Dec  <= pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_count <= 16'h0;
    end else if (npc_control && redirect_count != 16'hFFFF) begin
      redirect_count <= redirect_count + 16'd1;
    end
  end

endmodule
